// File: rtl/path_pkg.sv
// path_pkg: shared default sizes, node-index type and FSM state encoding for path_capture_buffer
package path_pkg;
  localparam int NODE_W_DEF = 5;
  localparam int DEPTH_DEF = 32;
  typedef logic [NODE_W_DEF-1:0] node_t;
  typedef enum logic [1:0] {CAPTURE, PLAY, DONE} state_t;
endpackage

// File: rtl/path_capture_buffer_if.sv
// path_capture_buffer_if: path-write, display and replay handshake bundle
// master: control FSM / renderer side (drives path_clr, wr_en, wr_node, disp_on, rd_req)
// slave: buffer side (drives rd_valid, rd_node, rd_last, path_len, overflow)
interface path_capture_buffer_if #(
  parameter int NODE_W = path_pkg::NODE_W_DEF,
  parameter int DEPTH = path_pkg::DEPTH_DEF
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  logic path_clr, wr_en, disp_on, rd_req, rd_valid, rd_last, overflow;
  logic [NODE_W-1:0] wr_node, rd_node;
  logic [CNT_W-1:0] path_len;
  modport master(output path_clr, wr_en, wr_node, disp_on, rd_req,
                 input rd_valid, rd_node, rd_last, path_len, overflow);
  modport slave(input path_clr, wr_en, wr_node, disp_on, rd_req,
                output rd_valid, rd_node, rd_last, path_len, overflow);
endinterface

// File: rtl/path_lifo_mem.sv
// path_lifo_mem: DEPTH x NODE_W register file, synchronous write, asynchronous read, no reset
// ports: clk, we_i/waddr_i/wdata_i write port, raddr_i/rdata_o read port
module path_lifo_mem #(
  parameter int NODE_W = 5,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [NODE_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [NODE_W-1:0]        rdata_o
);
  logic [NODE_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/path_capture_buffer.sv
// path_capture_buffer: captures path nodes destination-first and replays them source-first
// ports: clk, clear (sync active-high reset), bus (path_capture_buffer_if.slave)
// option: PATH_DEDUP_EN drops a write repeating the most recently stored node
module path_capture_buffer
  import path_pkg::*;
#(
  parameter int NODE_W = NODE_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic clk,
  input logic clear,
  path_capture_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  state_t state_q;
  logic [CNT_W-1:0] len_q, len_d;
  logic [AW-1:0] ptr_q, raddr;
  logic ovf_q, full, dup, accept;
  logic [NODE_W-1:0] rdata;
  always_comb begin
    full = len_q == CNT_W'(DEPTH);
`ifdef PATH_DEDUP_EN
    // the single read port looks at the newest entry while capturing
    raddr = state_q == PLAY ? ptr_q : AW'(len_q - 1'b1);
    dup = len_q != '0 && bus.wr_node == rdata;
`else
    raddr = ptr_q;
    dup = 1'b0;
`endif
    accept = state_q == CAPTURE && !bus.path_clr && bus.wr_en && !full && !dup;
    len_d = len_q + CNT_W'(accept);
  end
  path_lifo_mem #(.NODE_W(NODE_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk), .we_i(accept), .waddr_i(len_q[AW-1:0]), .wdata_i(bus.wr_node),
    .raddr_i(raddr), .rdata_o(rdata)
  );
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= CAPTURE;
      len_q <= '0;
      ovf_q <= 1'b0;
      ptr_q <= '0;
    end else if (bus.path_clr) begin
      state_q <= CAPTURE;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        CAPTURE: begin
          len_q <= len_d;
          if (bus.wr_en && full && !dup) ovf_q <= 1'b1;
          // a write in the transition cycle counts toward the replay start
          if (bus.disp_on) begin
            state_q <= len_d != '0 ? PLAY : DONE;
            ptr_q <= AW'(len_d - 1'b1);
          end
        end
        PLAY:
          if (!bus.disp_on) state_q <= CAPTURE;
          else if (bus.rd_req) begin
            if (ptr_q == '0) state_q <= DONE;
            else ptr_q <= ptr_q - 1'b1;
          end
        DONE: if (!bus.disp_on) state_q <= CAPTURE;
        default: state_q <= CAPTURE;
      endcase
    end
  end
  assign bus.rd_valid = state_q == PLAY;
  assign bus.rd_node = bus.rd_valid ? rdata : '0;
  assign bus.rd_last = bus.rd_valid && ptr_q == '0;
  assign bus.path_len = len_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_path_capture_buffer.sv
// tb_path_capture_buffer: directed plus randomized checks against a queue-based path model
module tb_path_capture_buffer;
  import path_pkg::*;
  logic clk = 1'b0, clear = 1'b1;
  int tests = 0, fails = 0;
  node_t q[$];
  bit ovf;
  path_capture_buffer_if b();
  path_capture_buffer dut(.clk(clk), .clear(clear), .bus(b));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, int obs, int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic void mclear();
    q.delete();
    ovf = 1'b0;
  endfunction
  function automatic void mwrite(node_t n);
`ifdef PATH_DEDUP_EN
    if (q.size() > 0 && q[$] == n) return;
`endif
    if (q.size() < DEPTH_DEF) q.push_back(n);
    else ovf = 1'b1;
  endfunction
  task automatic wr(node_t n);
    b.wr_en = 1'b1;
    b.wr_node = n;
    mwrite(n);
    tick();
    b.wr_en = 1'b0;
  endtask
  task automatic chk_len;
    chk("path_len", int'(b.path_len), q.size());
    chk("overflow", int'(b.overflow), int'(ovf));
  endtask
  task automatic replay(bit wr_same);
    int i, tries;
    node_t n;
    b.disp_on = 1'b1;
    if (wr_same) begin
      n = node_t'($urandom_range(0, 31));
      b.wr_en = 1'b1;
      b.wr_node = n;
      mwrite(n);
    end
    tick();
    b.wr_en = 1'b0;
    chk_len();
    i = q.size() - 1;
    tries = 0;
    if (i < 0) chk("empty_valid", int'(b.rd_valid), 0);
    while (i >= 0) begin
      chk("play_valid", int'(b.rd_valid), 1);
      chk("play_node", int'(b.rd_node), int'(q[i]));
      chk("play_last", int'(b.rd_last), int'(i == 0));
      b.rd_req = tries >= 2 || $urandom_range(0, 1) == 1;
      b.wr_en = $urandom_range(0, 1) == 1;
      b.wr_node = node_t'($urandom_range(0, 31));
      tick();
      if (b.rd_req) begin
        i--;
        tries = 0;
      end else tries++;
    end
    b.rd_req = 1'b0;
    b.wr_en = 1'b0;
    chk("done_valid", int'(b.rd_valid), 0);
    chk("done_last", int'(b.rd_last), 0);
    b.disp_on = 1'b0;
    tick();
    chk("back_valid", int'(b.rd_valid), 0);
    chk_len();
  endtask
  initial begin
    b.path_clr = 1'b0;
    b.wr_en = 1'b0;
    b.wr_node = '0;
    b.disp_on = 1'b0;
    b.rd_req = 1'b0;
    mclear();
    tick();
    tick();
    clear = 1'b0;
    chk_len();
    chk("rst_valid", int'(b.rd_valid), 0);
    chk("rst_last", int'(b.rd_last), 0);
    chk("rst_node", int'(b.rd_node), 0);
    // basic replay
    wr(7);
    wr(3);
    wr(0);
    chk_len();
    replay(1'b0);
    // dedup / repeated strobe
    b.path_clr = 1'b1;
    mclear();
    tick();
    b.path_clr = 1'b0;
    repeat (4) wr(9);
    repeat (2) wr(2);
`ifdef PATH_DEDUP_EN
    chk("dedup_len", int'(b.path_len), 2);
`else
    chk("dedup_len", int'(b.path_len), 6);
`endif
    replay(1'b0);
    // overflow
    b.path_clr = 1'b1;
    mclear();
    tick();
    b.path_clr = 1'b0;
    for (int k = 0; k < 33; k++) wr(node_t'(k));
    chk("ovf_len", int'(b.path_len), 32);
    chk("ovf_flag", int'(b.overflow), 1);
    b.disp_on = 1'b1;
    tick();
    chk("ovf_first", int'(b.rd_node), 31);
    b.disp_on = 1'b0;
    tick();
    replay(1'b0);
    b.path_clr = 1'b1;
    mclear();
    tick();
    b.path_clr = 1'b0;
    chk("clr_len", int'(b.path_len), 0);
    chk("clr_ovf", int'(b.overflow), 0);
    // path_clr beats wr_en
    b.path_clr = 1'b1;
    b.wr_en = 1'b1;
    b.wr_node = 5;
    tick();
    b.path_clr = 1'b0;
    b.wr_en = 1'b0;
    chk("prio_len", int'(b.path_len), 0);
    // clear mid-PLAY
    wr(1);
    wr(2);
    wr(3);
    b.disp_on = 1'b1;
    tick();
    chk("pre_clear_valid", int'(b.rd_valid), 1);
    clear = 1'b1;
    b.disp_on = 1'b0;
    tick();
    clear = 1'b0;
    mclear();
    chk("clear_valid", int'(b.rd_valid), 0);
    chk_len();
    wr(4);
    chk_len();
    // empty display
    b.path_clr = 1'b1;
    mclear();
    tick();
    b.path_clr = 1'b0;
    b.disp_on = 1'b1;
    repeat (3) begin
      tick();
      chk("empty_valid", int'(b.rd_valid), 0);
    end
    b.disp_on = 1'b0;
    tick();
    wr(6);
    chk_len();
    // abort and replay
    b.path_clr = 1'b1;
    mclear();
    tick();
    b.path_clr = 1'b0;
    wr(10);
    wr(20);
    wr(30);
    wr(11);
    b.disp_on = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("abort_node", int'(b.rd_node), int'(q[3-k]));
      b.rd_req = 1'b1;
      tick();
    end
    b.rd_req = 1'b0;
    b.disp_on = 1'b0;
    tick();
    chk("abort_valid", int'(b.rd_valid), 0);
    replay(1'b0);
    // randomized capture/replay rounds
    for (int it = 0; it < 15; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        b.path_clr = 1'b1;
        b.wr_en = 1'b1;
        b.wr_node = node_t'($urandom_range(0, 31));
        mclear();
        tick();
        b.path_clr = 1'b0;
        b.wr_en = 1'b0;
      end
      for (int k = $urandom_range(0, 36); k > 0; k--) begin
        if ($urandom_range(0, 4) != 0) wr(node_t'($urandom_range(0, 3)));
        else tick();
      end
      chk_len();
      replay(1'($urandom_range(0, 1)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
